// File: rtl/j_array_pkg.sv
// Shared types and sizing helpers for the systolic array job sequencer.
package j_array_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    STREAM,
    DRAIN,
    DONE
  } state_e;

  function automatic int lat_f(input int width, input int height);
    return width + height - 1;
  endfunction

  function automatic int cols_w_f(input int max_cols);
    return $clog2(max_cols + 1);
  endfunction

  function automatic int df_w_f(input int num_df);
    return (num_df > 2) ? $clog2(num_df) : 1;
  endfunction

  function automatic int row_w_f(input int height);
    return (height > 2) ? $clog2(height) : 1;
  endfunction

  // Phase counter must hold the longest phase length (load, stream or drain).
  function automatic int cnt_w_f(input int max_cols, input int lat, input int height);
    int m;
    m = max_cols;
    if (lat > m) m = lat;
    if (height > m) m = height;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/j_valid_delay_line.sv
// Fixed-depth 1-bit shift register with synchronous active-low clear.
module j_valid_delay_line #(
  parameter int DEPTH = 1
) (
  input  logic clk_i,
  input  logic clr_n_i,
  input  logic din_i,
  output logic dout_o
);

  logic [DEPTH-1:0] sr_q;

  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge clk_i) begin
        if (!clr_n_i) sr_q <= 1'b0;
        else          sr_q <= din_i;
      end
    end else begin : g_multi
      always_ff @(posedge clk_i) begin
        if (!clr_n_i) sr_q <= '0;
        else          sr_q <= {sr_q[DEPTH-2:0], din_i};
      end
    end
  endgenerate

  assign dout_o = sr_q[DEPTH-1];

endmodule

// File: rtl/j_array_sequencer.sv
// Job-level controller: weight load, column stream and drain phases for the
// systolic subarray, with dataflow mux select and result-valid tracking.
module j_array_sequencer
  import j_array_pkg::*;
#(
  parameter int SUBARRAY_WIDTH      = 32,
  parameter int SUBARRAY_HEIGHT     = 32,
  parameter int NUM_DATAFLOW_PER_MX = 8,
  parameter int MAX_COLS            = 4096
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   cmd_valid,
  output logic                                   cmd_ready,
  input  logic [cols_w_f(MAX_COLS)-1:0]          cmd_num_cols,
  input  logic [df_w_f(NUM_DATAFLOW_PER_MX)-1:0] cmd_dataflow,
  output logic                                   w_load_en,
  output logic [row_w_f(SUBARRAY_HEIGHT)-1:0]    w_row_sel,
  output logic                                   data_en,
  output logic [df_w_f(NUM_DATAFLOW_PER_MX)-1:0] mx_sel,
  output logic                                   result_en,
  output logic                                   busy,
  output logic                                   done
);

  localparam int LAT    = lat_f(SUBARRAY_WIDTH, SUBARRAY_HEIGHT);
  localparam int COLS_W = cols_w_f(MAX_COLS);
  localparam int DF_W   = df_w_f(NUM_DATAFLOW_PER_MX);
  localparam int ROW_W  = row_w_f(SUBARRAY_HEIGHT);
  localparam int CNT_W  = cnt_w_f(MAX_COLS, LAT, SUBARRAY_HEIGHT);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [COLS_W-1:0]  ncols_q, ncols_d;
  logic [DF_W-1:0]    df_q, df_d;

  logic               w_load_en_q, w_load_en_d;
  logic [ROW_W-1:0]   w_row_sel_q, w_row_sel_d;
  logic               data_en_q, data_en_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               accept;
  logic               load_last, stream_last, drain_last;

  assign accept      = cmd_valid && (state_q == IDLE);
  assign cnt_inc     = cnt_q + CNT_W'(1);
  assign load_last   = (cnt_q == CNT_W'(SUBARRAY_HEIGHT - 1));
  // Compare the incremented count so num_cols == MAX_COLS never needs a wrap.
  assign stream_last = (cnt_inc == CNT_W'(ncols_q));
  assign drain_last  = (cnt_q == CNT_W'(LAT - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ncols_q     <= '0;
      df_q        <= '0;
      w_load_en_q <= 1'b0;
      w_row_sel_q <= '0;
      data_en_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ncols_q     <= ncols_d;
      df_q        <= df_d;
      w_load_en_q <= w_load_en_d;
      w_row_sel_q <= w_row_sel_d;
      data_en_q   <= data_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // The phase counter restarts from zero on every state transition.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_inc;
    ncols_d = ncols_q;
    df_d    = df_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (accept) begin
          state_d = LOAD_W;
          ncols_d = cmd_num_cols;
          df_d    = cmd_dataflow;
        end
      end
      LOAD_W: begin
        if (load_last) begin
          cnt_d   = '0;
          state_d = (ncols_q == '0) ? DONE : STREAM;
        end
      end
      STREAM: begin
        if (stream_last) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_last) begin
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they land in flops aligned with the state.
  always_comb begin
    w_load_en_d = (state_d == LOAD_W);
    w_row_sel_d = (state_d == LOAD_W) ? cnt_d[ROW_W-1:0] : '0;
    data_en_d   = (state_d == STREAM);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
  end

  j_valid_delay_line #(
    .DEPTH(LAT)
  ) u_result_dly (
    .clk_i  (clk),
    .clr_n_i(reset),
    .din_i  (data_en_q),
    .dout_o (result_en)
  );

  assign cmd_ready = (state_q == IDLE);
  assign w_load_en = w_load_en_q;
  assign w_row_sel = w_row_sel_q;
  assign data_en   = data_en_q;
  assign mx_sel    = df_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_j_array_sequencer.sv
// Bench for j_array_sequencer: a 4x4 instance and a default-size instance.
module tb_j_array_sequencer;

  localparam int SW = 4, SH = 4, SNDF = 8, SMAX = 16, SLAT = SW + SH - 1;
  localparam int BW = 32, BH = 32, BNDF = 8, BMAX = 4096, BLAT = BW + BH - 1;
  localparam logic [13:0] RST_VEC = 14'b1_0_00000_0_000_0_0_0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        s_valid, b_valid;
  logic [12:0] num_cols;
  logic [2:0]  dataflow;
  logic        use_big;

  logic       s_ready, s_wl, s_de, s_re, s_busy, s_done;
  logic [1:0] s_row;
  logic [2:0] s_mx;
  logic       b_ready, b_wl, b_de, b_re, b_busy, b_done;
  logic [4:0] b_row;
  logic [2:0] b_mx;

  logic [13:0] vec_s, vec_b, o_vec;

  int pass_cnt = 0;
  int total_cnt = 0;

  j_array_sequencer #(
    .SUBARRAY_WIDTH(SW), .SUBARRAY_HEIGHT(SH),
    .NUM_DATAFLOW_PER_MX(SNDF), .MAX_COLS(SMAX)
  ) u_small (
    .clk(clk), .reset(rst_n), .cmd_valid(s_valid), .cmd_ready(s_ready),
    .cmd_num_cols(num_cols[4:0]), .cmd_dataflow(dataflow),
    .w_load_en(s_wl), .w_row_sel(s_row), .data_en(s_de), .mx_sel(s_mx),
    .result_en(s_re), .busy(s_busy), .done(s_done)
  );

  j_array_sequencer #(
    .SUBARRAY_WIDTH(BW), .SUBARRAY_HEIGHT(BH),
    .NUM_DATAFLOW_PER_MX(BNDF), .MAX_COLS(BMAX)
  ) u_big (
    .clk(clk), .reset(rst_n), .cmd_valid(b_valid), .cmd_ready(b_ready),
    .cmd_num_cols(num_cols), .cmd_dataflow(dataflow),
    .w_load_en(b_wl), .w_row_sel(b_row), .data_en(b_de), .mx_sel(b_mx),
    .result_en(b_re), .busy(b_busy), .done(b_done)
  );

  // Packed view: ready, w_load_en, row[4:0], data_en, mx[2:0], result_en, busy, done
  assign vec_s = {s_ready, s_wl, 3'b000, s_row, s_de, s_mx, s_re, s_busy, s_done};
  assign vec_b = {b_ready, b_wl, b_row, b_de, b_mx, b_re, b_busy, b_done};
  assign o_vec = use_big ? vec_b : vec_s;

  a_s_done_w: assert property (@(posedge clk) disable iff (!rst_n) s_done |=> !s_done)
    else $error("FAIL small_done_width");
  a_b_done_w: assert property (@(posedge clk) disable iff (!rst_n) b_done |=> !b_done)
    else $error("FAIL big_done_width");
  a_s_busy: assert property (@(posedge clk) disable iff (!rst_n) s_busy == !s_ready)
    else $error("FAIL small_busy_vs_ready");
  a_b_busy: assert property (@(posedge clk) disable iff (!rst_n) b_busy == !b_ready)
    else $error("FAIL big_busy_vs_ready");

  // Expected outputs at cycle c after accept, straight from the job timeline.
  function automatic logic [13:0] model(input int c, input int n, input int df,
                                        input int h, input int lat, input int d);
    logic wl, de, re;
    logic [4:0] row;
    wl  = (c >= 1) && (c <= h);
    row = wl ? 5'(c - 1) : 5'd0;
    de  = (c >= h + 1) && (c <= h + n);
    re  = (c >= h + 1 + lat) && (c <= h + n + lat);
    return {(c == d + 1), wl, row, de, 3'(df), re, (c <= d), (c == d)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_valid(input bit big, input logic v);
    if (big) b_valid = v;
    else     s_valid = v;
  endtask

  task automatic run_job(input bit big, input int n, input int df, input bit hold,
                         input int nn, input int ndf);
    int h, lat, d, de_cnt, re_cnt, done_at;
    logic [13:0] exp_v, obs_v;
    use_big = big;
    h   = big ? BH : SH;
    lat = big ? BLAT : SLAT;
    d   = (n == 0) ? h + 1 : h + n + lat + 1;
    de_cnt = 0; re_cnt = 0; done_at = -1;
    total_cnt++;
    if (o_vec[13] !== 1'b1) $display("FAIL job_ready_at_accept got %b want 1", o_vec[13]);
    else pass_cnt++;
    num_cols = 13'(n);
    dataflow = 3'(df);
    set_valid(big, 1'b1);
    for (int c = 1; c <= d + 1; c++) begin
      tick();
      if (c == 1) begin
        if (hold) begin
          num_cols = 13'(nn);
          dataflow = 3'(ndf);
        end else begin
          set_valid(big, 1'b0);
          num_cols = 13'($urandom);
          dataflow = 3'($urandom);
        end
      end
      exp_v = model(c, n, df, h, lat, d);
      obs_v = o_vec;
      if (!exp_v[12]) obs_v[11:7] = 5'd0;
      total_cnt++;
      if (obs_v !== exp_v)
        $display("FAIL job_cycle big=%0d n=%0d c=%0d got %b want %b", big, n, c, obs_v, exp_v);
      else pass_cnt++;
      if (o_vec[6]) de_cnt++;
      if (o_vec[2]) re_cnt++;
      if (o_vec[0] && done_at < 0) done_at = c;
    end
    total_cnt++;
    if (de_cnt != n) $display("FAIL data_en_count got %0d want %0d", de_cnt, n);
    else pass_cnt++;
    total_cnt++;
    if (re_cnt != n) $display("FAIL result_en_count got %0d want %0d", re_cnt, n);
    else pass_cnt++;
    total_cnt++;
    if (done_at != d) $display("FAIL done_cycle got %0d want %0d", done_at, d);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    s_valid = 1'b1; b_valid = 1'b1;
    num_cols = 13'd3; dataflow = 3'd5;
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++;
      if (vec_s !== RST_VEC) $display("FAIL reset_small got %b want %b", vec_s, RST_VEC);
      else pass_cnt++;
      total_cnt++;
      if (vec_b !== RST_VEC) $display("FAIL reset_big got %b want %b", vec_b, RST_VEC);
      else pass_cnt++;
    end
    s_valid = 1'b0; b_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    total_cnt++;
    if ({vec_s, vec_b} !== {RST_VEC, RST_VEC})
      $display("FAIL reset_release got %b %b want %b", vec_s, vec_b, RST_VEC);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    run_job(1'b0, 3, 5, 1'b0, 0, 0);
  endtask

  task automatic test_weight_only();
    run_job(1'b0, 0, 2, 1'b0, 0, 0);
  endtask

  task automatic test_back_to_back();
    run_job(1'b0, 2, 1, 1'b1, 2, 6);
    run_job(1'b0, 2, 6, 1'b0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      total_cnt++;
      if ({o_vec[13], o_vec[6], o_vec[2:0]} !== 5'b10000)
        $display("FAIL b2b_no_duplicate cycle=%0d got %b want idle", i, o_vec);
      else pass_cnt++;
    end
  endtask

  task automatic test_abort();
    logic [13:0] exp_v, obs_v;
    use_big = 1'b0;
    num_cols = 13'd5; dataflow = 3'd4;
    s_valid = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 1) s_valid = 1'b0;
      exp_v = model(c, 5, 4, SH, SLAT, SH + 5 + SLAT + 1);
      obs_v = o_vec;
      if (!exp_v[12]) obs_v[11:7] = 5'd0;
      total_cnt++;
      if (obs_v !== exp_v) $display("FAIL abort_prefix c=%0d got %b want %b", c, obs_v, exp_v);
      else pass_cnt++;
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    total_cnt++;
    if (vec_s !== RST_VEC) $display("FAIL abort_reset_values got %b want %b", vec_s, RST_VEC);
    else pass_cnt++;
    for (int i = 0; i < 30; i++) begin
      tick();
      total_cnt++;
      if ({vec_s[13], vec_s[6], vec_s[2:0]} !== 5'b10000)
        $display("FAIL abort_no_tail cycle=%0d got %b", i, vec_s);
      else pass_cnt++;
    end
    run_job(1'b0, 1, 7, 1'b0, 0, 0);
  endtask

  task automatic test_random();
    int n, df, gap;
    for (int j = 0; j < 8; j++) begin
      n   = $urandom_range(0, SMAX);
      df  = $urandom_range(0, SNDF - 1);
      gap = $urandom_range(0, 3);
      run_job(1'b0, n, df, 1'b0, 0, 0);
      for (int g = 0; g < gap; g++) begin
        tick();
        total_cnt++;
        if ({o_vec[13], o_vec[5:3], o_vec[2:0]} !== {1'b1, 3'(df), 3'b000})
          $display("FAIL random_idle_gap got %b", o_vec);
        else pass_cnt++;
      end
    end
    for (int j = 0; j < 2; j++) begin
      n  = $urandom_range(0, 10);
      df = $urandom_range(0, BNDF - 1);
      run_job(1'b1, n, df, 1'b0, 0, 0);
    end
  endtask

  task automatic test_max_cols();
    run_job(1'b0, SMAX, 0, 1'b0, 0, 0);
    run_job(1'b1, BMAX, 3, 1'b0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    s_valid = 1'b0;
    b_valid = 1'b0;
    num_cols = '0;
    dataflow = '0;
    use_big = 1'b0;
    test_reset();
    test_basic();
    test_weight_only();
    test_back_to_back();
    test_abort();
    test_random();
    test_max_cols();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/j_array_sequencer.md
# j_array_sequencer

Job-level controller for the systolic subarray datapath, driving the `j_max_power_wrapper` array.
- Accepts one matrix-tile command at a time over a valid/ready handshake.
- Sequences the weight-load, data-stream and drain phases with cycle-exact control strobes.
- Selects which of the NUM_DATAFLOW_PER_MX dataflows feeds the array's input multiplexer.
- Flags the cycles in which valid result columns leave the array.

## Interface
Parameters:
- SUBARRAY_WIDTH, 32, array columns.
- SUBARRAY_HEIGHT, 32, array rows; equals the number of weight rows loaded per job.
- NUM_DATAFLOW_PER_MX, 8, dataflow inputs per multiplexer. Must be ≥2.
- MAX_COLS, 4096, largest column count per job.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low. Sampled only on the rising edge of clk.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer idle, able to accept a command.
- cmd_num_cols  in  $clog2(MAX_COLS+1)  input columns to stream (0..MAX_COLS).
- cmd_dataflow  in  $clog2(NUM_DATAFLOW_PER_MX)  dataflow select.
- w_load_en  out  1  weight-load strobe.
- w_row_sel  out  $clog2(SUBARRAY_HEIGHT)  weight row being loaded.
- data_en  out  1  activation column enters the array this cycle.
- mx_sel  out  $clog2(NUM_DATAFLOW_PER_MX)  dataflow mux select.
- result_en  out  1  valid result column at array output.
- busy  out  1  job in progress.
- done  out  1  one-cycle job-complete pulse.

## Operation
- **Handshake:** a command is accepted when cmd_valid && cmd_ready.
  - cmd_ready = (state == IDLE).
  - cmd_num_cols and cmd_dataflow are latched on accept.
  - mx_sel drives the latched dataflow for the whole job and holds its value in IDLE.
  - Commands presented while busy are ignored; cmd_valid may stay high.
- **FSM states:** IDLE → LOAD_W → STREAM → DRAIN → DONE → IDLE.
  - IDLE: wait for accept.
  - LOAD_W: exactly SUBARRAY_HEIGHT cycles. w_load_en=1; w_row_sel counts 0..SUBARRAY_HEIGHT-1.
  - STREAM: exactly num_cols cycles with data_en=1.
  - DRAIN: exactly LAT = SUBARRAY_WIDTH+SUBARRAY_HEIGHT-1 cycles with data_en=0.
  - DONE: one cycle, done=1.
- **num_cols = 0:** LOAD_W goes directly to DONE, skipping STREAM and DRAIN. This is a weight-only job.
- **num_cols = MAX_COLS:** the counter must not wrap. The STREAM cycle count is exact.
- **result_en:** equals data_en delayed by exactly LAT cycles through a LAT-deep shift register. The last result_en therefore falls in the final DRAIN cycle, and result_en is never asserted in DONE or IDLE.
- **busy:** 1 in every state except IDLE.
- **Reset:**
  - Applies on the next rising edge in any state, including mid-job.
  - Forces IDLE and clears all counters and the delay line.
  - No done pulse is generated for the aborted job.
- **Output reset values:** cmd_ready=1 (IDLE), w_load_en=0, w_row_sel=0, data_en=0, mx_sel=0, result_en=0, busy=0, done=0.
- **Registered outputs:** all outputs except cmd_ready are registered. There is no combinational path from cmd_* to any output.

## Timing
- Accept at edge T (cycle T):
  - LOAD_W occupies T+1..T+H.
  - STREAM occupies T+H+1..T+H+N.
  - DRAIN occupies T+H+N+1..T+H+N+LAT.
  - DONE is at T+H+N+LAT+1.
  - cmd_ready=1 again at T+H+N+LAT+2.
- Job latency, accept to done: H+N+LAT+1 cycles, or H+1 cycles when N=0.
- Throughput: a new command is accepted in the first IDLE cycle after DONE. Back-to-back jobs are separated by exactly one IDLE cycle.
- First result_en for a job: T+H+1+LAT.

## Structure
- **Shared package `j_array_pkg`:**
  - state enum (IDLE, LOAD_W, STREAM, DRAIN, DONE).
  - localparam function for LAT from array dimensions.
  - width helpers for the command fields.
- **Sub-module `j_valid_delay_line`:** parameterized depth, 1-bit shift register with synchronous active-low clear. It generates result_en.
- Everything else lives in the top module: the FSM plus one shared phase counter, reloaded at each transition.

## Test plan
All scenarios use W=H=4 (LAT=7) unless noted; accept at cycle 0.
- **N=3, dataflow=5:**
  - w_load_en cycles 1–4 with w_row_sel 0,1,2,3.
  - data_en cycles 5–7; result_en cycles 12–14.
  - done at cycle 15 only; cmd_ready=1 at 16; mx_sel=5 during cycles 1–15.
- **N=0:** w_load_en cycles 1–4, done at 5, data_en and result_en never asserted.
- **cmd_valid held high for two jobs (N=2 each):** second accept exactly one cycle after the first done; no command is dropped or duplicated.
- **reset low at cycle 6 during STREAM (N=5):** from cycle 7, all outputs are at reset values, no result_en or done for the aborted job, cmd_ready=1.
- **Default params, N=MAX_COLS:** exactly 4096 data_en cycles, exactly 4096 result_en cycles, done at cycle 32+4096+63+1.
- **Assertions:**
  - result_en == data_en delayed by LAT cycles.
  - done is one cycle wide.
  - busy == !cmd_ready at all times.
